// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the registered 2:1 selector
package mux_pkg;
  localparam int MUX_DATA_W_DEFAULT = 32;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  localparam logic [63:0] SALIDA_RST = '0;
endpackage

// File: rtl/mux_2in_1out_core.sv
// mux_2in_1out_core: combinational bitwise select of DatoA/DatoB by Sel
import mux_pkg::*;
module mux_2in_1out_core #(
  parameter int DATA_W = MUX_DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] DatoA,
  input  logic [DATA_W-1:0] DatoB,
  input  logic              Sel,
  output logic [DATA_W-1:0] dato
);
  always_comb dato = (Sel == SEL_B) ? DatoB : DatoA;
endmodule

// File: rtl/mux_2in_1out_reg.sv
// mux_2in_1out_reg: registered 2:1 selector with valid; MUX_2IN_1OUT_PARITY_EN adds registered Paridad
import mux_pkg::*;
module mux_2in_1out_reg #(
  parameter int DATA_W = MUX_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] DatoA,
  input  logic [DATA_W-1:0] DatoB,
  input  logic              Sel,
  input  logic              Valid_in,
  output logic [DATA_W-1:0] Salida,
  output logic              Sel_q,
  output logic              Valid_out
`ifdef MUX_2IN_1OUT_PARITY_EN
  , output logic            Paridad
`endif
);
  logic [DATA_W-1:0] dato;
  mux_2in_1out_core #(.DATA_W(DATA_W)) u_core (
    .DatoA(DatoA),
    .DatoB(DatoB),
    .Sel(Sel),
    .dato(dato)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Salida    <= SALIDA_RST[DATA_W-1:0];
      Sel_q     <= SEL_A;
      Valid_out <= 1'b0;
`ifdef MUX_2IN_1OUT_PARITY_EN
      Paridad   <= 1'b0;
`endif
    end else begin
      Valid_out <= Valid_in;
      if (Valid_in) begin
        Salida <= dato;
        Sel_q  <= Sel;
`ifdef MUX_2IN_1OUT_PARITY_EN
        Paridad <= ^dato;
`endif
      end
    end
endmodule

// File: tb/tb_mux_2in_1out_reg.sv
// tb_mux_2in_1out_reg: directed and random checks of mux_2in_1out_reg against a behavioural model
module tb_mux_2in_1out_reg;
  localparam int DATA_W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [DATA_W-1:0] DatoA = '0, DatoB = '0;
  logic Sel = 1'b0, Valid_in = 1'b0;
  logic [DATA_W-1:0] Salida;
  logic Sel_q, Valid_out;
  int errors = 0, checks = 0;
  logic check_en = 1'b0;
  logic [DATA_W-1:0] m_salida = '0;
  logic m_sel = 1'b0, m_valid = 1'b0;
`ifdef MUX_2IN_1OUT_PARITY_EN
  logic Paridad;
  logic m_par = 1'b0;
`endif
  mux_2in_1out_reg #(.DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .DatoA(DatoA),
    .DatoB(DatoB),
    .Sel(Sel),
    .Valid_in(Valid_in),
    .Salida(Salida),
    .Sel_q(Sel_q),
    .Valid_out(Valid_out)
`ifdef MUX_2IN_1OUT_PARITY_EN
    , .Paridad(Paridad)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_salida = '0;
    m_sel = 1'b0;
    m_valid = 1'b0;
`ifdef MUX_2IN_1OUT_PARITY_EN
    m_par = 1'b0;
`endif
  endtask
  // Drive one set of inputs, let one rising edge sample them, then advance the model
  task automatic step(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic s, input logic v);
    logic [DATA_W-1:0] w;
    DatoA = a;
    DatoB = b;
    Sel = s;
    Valid_in = v;
    w = s ? b : a;
    @(posedge clk);
    m_valid = v;
    if (v) begin
      m_salida = w;
      m_sel = s;
`ifdef MUX_2IN_1OUT_PARITY_EN
      m_par = ($countones(w) % 2) == 1;
`endif
    end
    #1;
  endtask
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_salida", 64'(Salida), 64'd0);
    chk("async_rst_valid", 64'(Valid_out), 64'd0);
    #1 rst_n = 1'b1;
  endtask
  always @(negedge clk)
    if (check_en) begin
      chk("cyc_salida", 64'(Salida), 64'(m_salida));
      chk("cyc_sel_q", 64'(Sel_q), 64'(m_sel));
      chk("cyc_valid", 64'(Valid_out), 64'(m_valid));
`ifdef MUX_2IN_1OUT_PARITY_EN
      chk("cyc_paridad", 64'(Paridad), 64'(m_par));
`endif
    end
  initial begin
    DatoA = 32'd1;
    DatoB = 32'd2;
    Sel = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_salida", 64'(Salida), 64'd0);
    chk("rst_valid", 64'(Valid_out), 64'd0);
    chk("rst_sel_q", 64'(Sel_q), 64'd0);
    #1 rst_n = 1'b1;
    model_reset();
    check_en = 1'b1;
    step(32'd1, 32'd2, 1'b0, 1'b1);
    chk("first_load_salida", 64'(Salida), 64'd1);
    chk("first_load_sel_q", 64'(Sel_q), 64'd0);
    chk("first_load_valid", 64'(Valid_out), 64'd1);
    step(32'd1, 32'd2, 1'b1, 1'b1);
    chk("sel_b_salida", 64'(Salida), 64'd2);
    chk("sel_b_sel_q", 64'(Sel_q), 64'd1);
    step(32'd6, 32'd4, 1'b1, 1'b1);
    chk("data_chg_b", 64'(Salida), 64'd4);
    step(32'd6, 32'd4, 1'b0, 1'b1);
    chk("data_chg_a", 64'(Salida), 64'd6);
`ifdef MUX_2IN_1OUT_PARITY_EN
    chk("par_six", 64'(Paridad), 64'd0);
`endif
    step(32'hFFFF_FFFF, 32'd4, 1'b0, 1'b0);
    chk("hold_salida", 64'(Salida), 64'd6);
    chk("hold_valid", 64'(Valid_out), 64'd0);
    chk("hold_sel_q", 64'(Sel_q), 64'd0);
`ifdef MUX_2IN_1OUT_PARITY_EN
    step(32'd6, 32'h7, 1'b1, 1'b1);
    chk("par_seven", 64'(Paridad), 64'd1);
`endif
    step(32'hA5A5_0001, 32'h5A5A_0002, 1'b1, 1'b1);
    step(32'hA5A5_0003, 32'h5A5A_0004, 1'b0, 1'b1);
    pulse_reset();
    step(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
    chk("post_rst_load", 64'(Salida), 64'h1234_5678);
    chk("post_rst_valid", 64'(Valid_out), 64'd1);
    for (int i = 0; i < 400; i++) begin
      step($urandom, $urandom, 1'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end
    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
